trap_ctrl: RTL and testbench

- Trap sequencer: the initiator for the CSR file's exception/interrupt write port.
- Detects ecall, mret and machine-timer interrupt at the instruction commit point.
- Drives the mepc/mcause/mstatus write strobes into the CSR file.
- Redirects the PC to mtvec on trap entry, or to mepc on mret; stalls the pipeline while sequencing.

---
 rtl/trap_ctrl_pkg.sv | 20 ++
 rtl/trap_ctrl_mstatus_xform.sv | 27 ++
 rtl/trap_ctrl.sv | 144 ++++++++++++++
 tb/tb_trap_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared constants for the trap sequencer: mstatus bit positions,
// exception cause codes and the 2-bit FSM state encoding.
package trap_ctrl_pkg;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam int CAUSE_ECALL_M  = 11;
    localparam int CAUSE_TIMER_M  = 7;

    typedef logic [1:0] trap_state_t;

    localparam trap_state_t TRAP_IDLE = 2'd0;
    localparam trap_state_t TRAP_SAVE = 2'd1;
    localparam trap_state_t TRAP_JUMP = 2'd2;
    localparam trap_state_t TRAP_RET  = 2'd3;

endpackage

// File: rtl/trap_ctrl_mstatus_xform.sv
// Combinational mstatus update shared by trap entry and mret.
// Ports: i_mstatus (current value), i_ret (0=enter, 1=return),
//        o_mstatus (value to write back).
module trap_ctrl_mstatus_xform
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_mstatus,
    input  logic            i_ret,
    output logic [XLEN-1:0] o_mstatus
);

    always_comb begin
        o_mstatus = i_mstatus;
        // M-only core: MPP is always forced to machine mode.
        o_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        if (i_ret) begin
            o_mstatus[MSTATUS_MIE]  = i_mstatus[MSTATUS_MPIE];
            o_mstatus[MSTATUS_MPIE] = 1'b1;
        end else begin
            o_mstatus[MSTATUS_MPIE] = i_mstatus[MSTATUS_MIE];
            o_mstatus[MSTATUS_MIE]  = 1'b0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: takes ecall / mret / machine-timer irq at commit,
// writes mepc/mcause/mstatus and redirects the PC.
// Inputs: commit info (i_valid, i_pc, i_ecall, i_mret), i_timer_irq,
//         CSR values i_mtvec, i_mstatus, i_mepc.
// Outputs: CSR write ports, o_kill, o_busy, o_redirect/o_redirect_pc.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ECALL_CAUSE = CAUSE_ECALL_M,
    parameter int TIMER_CAUSE = CAUSE_TIMER_M
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_ecall,
    input  logic            i_mret,
    input  logic            i_timer_irq,
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [XLEN-1:0] i_mstatus,
    input  logic [XLEN-1:0] i_mepc,
    output logic            o_mepc_wen,
    output logic [XLEN-1:0] o_mepc_wdata,
    output logic            o_mcause_wen,
    output logic [XLEN-1:0] o_mcause_wdata,
    output logic            o_mstatus_wen,
    output logic [XLEN-1:0] o_mstatus_wdata,
    output logic            o_kill,
    output logic            o_busy,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirect_pc
);

    localparam logic [XLEN-1:0] TIMER_W = XLEN'(TIMER_CAUSE);
    localparam logic [XLEN-1:0] IRQ_CAUSE =
        {1'b1, TIMER_W[XLEN-2:0]};
    localparam logic [XLEN-1:0] EXC_CAUSE = XLEN'(ECALL_CAUSE);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    trap_state_t     state;
    trap_state_t     state_nxt;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] cause_nxt;
    logic            capture;
    logic            save_q;
    logic            mst_wen_q;
    logic            redir_q;
    logic            busy_q;
    logic            idle;
    logic            irq_take;
    logic            ecall_take;
    logic            mret_take;
    logic [XLEN-1:0] mstatus_new;

    assign idle       = (state == TRAP_IDLE);
    assign irq_take   = idle & i_valid & i_timer_irq
                      & i_mstatus[MSTATUS_MIE];
    assign ecall_take = idle & i_valid & i_ecall & ~irq_take;
    assign mret_take  = idle & i_valid & i_mret & ~irq_take
                      & ~i_ecall;

    assign capture = irq_take | ecall_take;
    assign o_kill  = capture;

    always_comb begin
        state_nxt = state;
        cause_nxt = EXC_CAUSE;
        if (irq_take) begin
            cause_nxt = IRQ_CAUSE;
        end
        case (state)
            TRAP_IDLE: begin
                if (capture) begin
                    state_nxt = TRAP_SAVE;
                end else if (mret_take) begin
                    state_nxt = TRAP_RET;
                end
            end
            TRAP_SAVE: state_nxt = TRAP_JUMP;
            TRAP_JUMP: state_nxt = TRAP_IDLE;
            TRAP_RET:  state_nxt = TRAP_IDLE;
            default:   state_nxt = TRAP_IDLE;
        endcase
    end

    // Strobes are flops loaded from the next state so they line up
    // exactly with the cycle spent in SAVE / JUMP / RET.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= TRAP_IDLE;
            epc       <= '0;
            cause     <= '0;
            save_q    <= 1'b0;
            mst_wen_q <= 1'b0;
            redir_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                epc   <= i_pc;
                cause <= cause_nxt;
            end
            save_q    <= (state_nxt == TRAP_SAVE);
            mst_wen_q <= (state_nxt == TRAP_SAVE)
                       | (state_nxt == TRAP_RET);
            redir_q   <= (state_nxt == TRAP_JUMP)
                       | (state_nxt == TRAP_RET);
            busy_q    <= (state_nxt != TRAP_IDLE);
        end
    end

    trap_ctrl_mstatus_xform #(
        .XLEN (XLEN)
    ) u_xform (
        .i_mstatus (i_mstatus),
        .i_ret     (state == TRAP_RET),
        .o_mstatus (mstatus_new)
    );

    assign o_busy        = busy_q;
    assign o_mepc_wen    = save_q;
    assign o_mcause_wen  = save_q;
    assign o_mstatus_wen = mst_wen_q;
    assign o_redirect    = redir_q;

    assign o_mepc_wdata    = save_q    ? epc         : '0;
    assign o_mcause_wdata  = save_q    ? cause       : '0;
    assign o_mstatus_wdata = mst_wen_q ? mstatus_new : '0;

    // Direct-mode vectoring only: low two mtvec bits are the mode.
    always_comb begin
        o_redirect_pc = '0;
        if (redir_q) begin
            if (state == TRAP_JUMP) begin
                o_redirect_pc = i_mtvec & ALIGN_MASK;
            end else begin
                o_redirect_pc = i_mepc;
            end
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl.
// Drives commit stimulus 1ns after posedge and checks after it.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [31:0] pc;
    logic        ecall;
    logic        mret;
    logic        irq;
    logic [31:0] mtvec;
    logic [31:0] mstatus;
    logic [31:0] mepc;
    logic        mepc_wen;
    logic [31:0] mepc_wdata;
    logic        mcause_wen;
    logic [31:0] mcause_wdata;
    logic        mstatus_wen;
    logic [31:0] mstatus_wdata;
    logic        kill;
    logic        busy;
    logic        redirect;
    logic [31:0] redirect_pc;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_valid         (valid),
        .i_pc            (pc),
        .i_ecall         (ecall),
        .i_mret          (mret),
        .i_timer_irq     (irq),
        .i_mtvec         (mtvec),
        .i_mstatus       (mstatus),
        .i_mepc          (mepc),
        .o_mepc_wen      (mepc_wen),
        .o_mepc_wdata    (mepc_wdata),
        .o_mcause_wen    (mcause_wen),
        .o_mcause_wdata  (mcause_wdata),
        .o_mstatus_wen   (mstatus_wen),
        .o_mstatus_wdata (mstatus_wdata),
        .o_kill          (kill),
        .o_busy          (busy),
        .o_redirect      (redirect),
        .o_redirect_pc   (redirect_pc)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        chk("q_busy", {31'd0, busy}, 32'd0);
        chk("q_mepc_wen", {31'd0, mepc_wen}, 32'd0);
        chk("q_mst_wen", {31'd0, mstatus_wen}, 32'd0);
        chk("q_redir", {31'd0, redirect}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        valid = 0; pc = 0; ecall = 0; mret = 0; irq = 0;
        mtvec = 32'h8000_0103; mstatus = 0; mepc = 0;
        tick(); tick();
        rst = 1'b0;
        #1;
        quiet();
        chk("rst_cause_wen", {31'd0, mcause_wen}, 32'd0);

        // ecall
        mstatus = 32'h8; pc = 32'h8000_0010;
        valid = 1; ecall = 1;
        #1;
        chk("ec_kill", {31'd0, kill}, 32'd1);
        tick();
        valid = 0; ecall = 0;
        #1;
        chk("ec_mepc_wen", {31'd0, mepc_wen}, 32'd1);
        chk("ec_mepc", mepc_wdata, 32'h8000_0010);
        chk("ec_cause", mcause_wdata, 32'd11);
        chk("ec_mst_wen", {31'd0, mstatus_wen}, 32'd1);
        chk("ec_mst", mstatus_wdata, 32'h1880);
        chk("ec_busy", {31'd0, busy}, 32'd1);
        chk("ec_redir0", {31'd0, redirect}, 32'd0);
        tick();
        chk("ec_redir", {31'd0, redirect}, 32'd1);
        chk("ec_rpc", redirect_pc, 32'h8000_0100);
        chk("ec_wen_off", {31'd0, mepc_wen}, 32'd0);
        chk("ec_wd_off", mepc_wdata, 32'd0);
        tick();
        quiet();

        // mret
        mepc = 32'h8000_0014; mstatus = 32'h1880;
        valid = 1; mret = 1;
        #1;
        chk("mr_kill", {31'd0, kill}, 32'd0);
        tick();
        valid = 0; mret = 0;
        #1;
        chk("mr_mst_wen", {31'd0, mstatus_wen}, 32'd1);
        chk("mr_mst", mstatus_wdata, 32'h1888);
        chk("mr_redir", {31'd0, redirect}, 32'd1);
        chk("mr_rpc", redirect_pc, 32'h8000_0014);
        chk("mr_mepc_wen", {31'd0, mepc_wen}, 32'd0);
        tick();
        quiet();

        // timer irq, MIE=1
        mstatus = 32'h8; pc = 32'h8000_0040;
        valid = 1; irq = 1;
        #1;
        chk("irq_kill", {31'd0, kill}, 32'd1);
        tick();
        valid = 0; irq = 0;
        #1;
        chk("irq_cause", mcause_wdata, 32'h8000_0007);
        chk("irq_mepc", mepc_wdata, 32'h8000_0040);
        tick();
        chk("irq_redir", {31'd0, redirect}, 32'd1);
        chk("irq_rpc", redirect_pc, 32'h8000_0100);
        tick();
        quiet();

        // timer irq, MIE=0: ignored
        mstatus = 32'h0; valid = 1; irq = 1;
        #1;
        chk("nirq_kill", {31'd0, kill}, 32'd0);
        tick();
        quiet();
        tick();
        quiet();
        valid = 0; irq = 0;

        // irq + ecall together, then ecall pulses while busy
        mstatus = 32'h8; pc = 32'h8000_0050;
        valid = 1; ecall = 1; irq = 1;
        #1;
        chk("both_kill", {31'd0, kill}, 32'd1);
        tick();
        irq = 0;
        pc = 32'h8000_0090;
        #1;
        chk("both_cause", mcause_wdata, 32'h8000_0007);
        chk("both_mepc", mepc_wdata, 32'h8000_0050);
        chk("both_busy1", {31'd0, busy}, 32'd1);
        chk("busy_kill1", {31'd0, kill}, 32'd0);
        tick();
        chk("both_redir", {31'd0, redirect}, 32'd1);
        chk("both_busy2", {31'd0, busy}, 32'd1);
        chk("busy_kill2", {31'd0, kill}, 32'd0);
        tick();
        valid = 0; ecall = 0;
        #1;
        quiet();
        tick();
        quiet();

        // reset during SAVE
        mstatus = 32'h8; pc = 32'h8000_0060;
        valid = 1; ecall = 1;
        tick();
        valid = 0; ecall = 0;
        #1;
        chk("rs_save", {31'd0, mepc_wen}, 32'd1);
        rst = 1;
        tick();
        rst = 0;
        #1;
        quiet();
        tick();
        quiet();

        // normal ecall after reset
        pc = 32'h8000_0070; valid = 1; ecall = 1;
        #1;
        chk("post_kill", {31'd0, kill}, 32'd1);
        tick();
        valid = 0; ecall = 0;
        #1;
        chk("post_mepc", mepc_wdata, 32'h8000_0070);
        chk("post_cause", mcause_wdata, 32'd11);
        tick();
        chk("post_redir", {31'd0, redirect}, 32'd1);
        chk("post_rpc", redirect_pc, 32'h8000_0100);
        tick();
        quiet();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
